// File: rtl/lsu_mem_stage.sv
// Load/store unit behind the execute ALU: takes the ALU result as the effective address,
// runs one req/gnt/rvalid data-memory transaction at a time and returns aligned load data.
module lsu_mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ex_valid,
    input  logic                  ex_we,
    input  logic [1:0]            ex_size,
    input  logic                  ex_unsigned,
    input  logic [ADDR_W-1:0]     ex_addr,
    input  logic [DATA_W-1:0]     ex_wdata,
    output logic                  lsu_busy,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_W-1:0]     dmem_addr,
    output logic [DATA_W/8-1:0]   dmem_be,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  done,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     wb_rdata,
    output logic                  misaligned,
    output logic [ADDR_W-1:0]     fault_addr,
    output logic [1:0]            dbg_state
);

    // Handshake: dmem_req stays high with address/be/wdata frozen until the cycle dmem_gnt
    // is seen high; dmem_rvalid is only meaningful while a load waits in S_WAIT, never in
    // the grant cycle. Upstream presents ex_valid and must hold the op while lsu_busy=1.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [1:0]          r_off;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W/8-1:0] r_be;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;
    logic                r_wb_valid;
    logic [DATA_W-1:0]   r_wb_rdata;
    logic                r_mis;
    logic [ADDR_W-1:0]   r_fault;

    logic [1:0]          w_off;
    logic                w_bad;
    logic                w_accept;
    logic                w_reject;
    logic                w_store_done;
    logic                w_load_done;
    logic [DATA_W/8-1:0] w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_lane;
    logic [DATA_W-1:0]   w_ld;

    assign w_off    = ex_addr[1:0];
    assign w_bad    = (ex_size == 2'b11)
                    | ((ex_size == 2'b01) & w_off[0])
                    | ((ex_size == 2'b10) & (w_off != 2'b00));
    assign w_accept = (r_state == S_IDLE) & ex_valid & ~w_bad;
    assign w_reject = (r_state == S_IDLE) & ex_valid & w_bad;

    always_comb begin
        w_next       = r_state;
        w_store_done = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (dmem_gnt) begin
                    w_next       = r_we ? S_IDLE : S_WAIT;
                    w_store_done = r_we;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    w_next      = S_IDLE;
                    w_load_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Store lanes are replicated so the memory picks the right copy using only dmem_be.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = '0;
        if (ex_we) begin
            case (ex_size)
                2'b00: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {2{ex_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = ex_wdata;
                end
            endcase
        end
    end

    assign w_lane = dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ld = w_lane;
        case (r_size)
            2'b00:   w_ld = {{(DATA_W-8){w_lane[7] & ~r_unsigned}}, w_lane[7:0]};
            2'b01:   w_ld = {{(DATA_W-16){w_lane[15] & ~r_unsigned}}, w_lane[15:0]};
            default: w_ld = w_lane;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_done     <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rdata <= '0;
            r_mis      <= 1'b0;
            r_fault    <= '0;
        end else begin
            r_state    <= w_next;
            r_done     <= w_store_done | w_load_done;
            r_wb_valid <= w_load_done;
            r_mis      <= w_reject;
            if (w_accept) begin
                r_we       <= ex_we;
                r_size     <= ex_size;
                r_unsigned <= ex_unsigned;
                r_off      <= w_off;
                r_addr     <= {ex_addr[ADDR_W-1:2], 2'b00};
                r_be       <= w_be;
                r_wdata    <= w_wdata;
            end
            if (w_reject) r_fault <= ex_addr;
            if (w_load_done) r_wb_rdata <= w_ld;
        end
    end

    assign lsu_busy   = (r_state != S_IDLE);
    assign dmem_req   = (r_state == S_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign done       = r_done;
    assign wb_valid   = r_wb_valid;
    assign wb_rdata   = r_wb_rdata;
    assign misaligned = r_mis;
    assign fault_addr = r_fault;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage: a bus-side responder drives gnt/rvalid with random
// latency while a spec-level model predicts bus fields, pulses and load results.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        ex_we;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        done;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic        misaligned;
    logic [31:0] fault_addr;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] last_wb;

    lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_busy(lsu_busy), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .done(done), .wb_valid(wb_valid), .wb_rdata(wb_rdata),
        .misaligned(misaligned), .fault_addr(fault_addr), .dbg_state(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model, straight from the access rules
    function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
        return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] model_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
        int off = addr % 4;
        if (!we || size == 2) return 32'd15;
        if (size == 0) return 32'd1 << off;
        return 32'd3 << off;
    endfunction

    function automatic logic [31:0] model_wdata(input logic we, input logic [1:0] size, input logic [31:0] d);
        if (!we) return 32'd0;
        if (size == 0) return (d % 256) * 32'h0101_0101;
        if (size == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] lane = rdata >> (8 * (addr % 4));
        logic [31:0] v;
        if (size == 0) begin
            v = lane % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = lane % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // driver: entered and left just after a falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = $urandom;
            step();
            chk("idle_wb_valid", wb_valid, 0);
            chk("idle_done", done, 0);
            chk("idle_req", dmem_req, 0);
            chk("idle_busy", lsu_busy, 0);
        end
        dmem_rvalid = 1'b0;
    endtask

    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        logic [31:0] exp_wb;
        chk("busy_before", lsu_busy, 0);
        ex_valid = 1'b1; ex_we = we; ex_size = size; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wdata;
        step();
        ex_valid = 1'b0;
        ex_wdata = $urandom;
        if (is_bad(size, addr)) begin
            chk("mis_pulse", misaligned, 1);
            chk("mis_fault_addr", fault_addr, addr);
            chk("mis_no_req", dmem_req, 0);
            chk("mis_busy", lsu_busy, 0);
            step();
            chk("mis_drop", misaligned, 0);
            chk("mis_no_req2", dmem_req, 0);
            return;
        end
        for (int i = 0; i <= gnt_dly; i++) begin
            chk("req", dmem_req, 1);
            chk("busy_req", lsu_busy, 1);
            chk("req_we", dmem_we, we);
            chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            chk("req_be", dmem_be, model_be(we, size, addr));
            chk("req_wdata", dmem_wdata, model_wdata(we, size, wdata));
            if (i == gnt_dly) dmem_gnt = 1'b1;
            step();
        end
        dmem_gnt = 1'b0;
        chk("req_dropped", dmem_req, 0);
        if (we) begin
            chk("st_done", done, 1);
            chk("st_wb_valid", wb_valid, 0);
            chk("st_busy", lsu_busy, 0);
            chk("wb_hold", wb_rdata, last_wb);
            return;
        end
        exp_q.push_back(model_load(size, uns, addr, rdata));
        for (int i = 0; i < rv_dly; i++) begin
            chk("wait_busy", lsu_busy, 1);
            chk("wait_done", done, 0);
            chk("wait_wb_valid", wb_valid, 0);
            step();
        end
        chk("wait_busy_last", lsu_busy, 1);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        exp_wb = exp_q.pop_front();
        chk("ld_done", done, 1);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_busy", lsu_busy, 0);
        chk("ld_wb_rdata", wb_rdata, exp_wb);
        last_wb = exp_wb;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; last_wb = 32'd0;
        reset_n = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_size = 2'b00; ex_unsigned = 1'b0;
        ex_addr = '0; ex_wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #1;
        chk("rst_busy", lsu_busy, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rdata", wb_rdata, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_fault", fault_addr, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // store byte at top lane
        run_op(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0);
        idle(1);
        // load half signed / unsigned from upper half
        run_op(0, 2'b01, 0, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234);
        chk("lh_signed", last_wb, 32'hFFFF_8001);
        run_op(0, 2'b01, 1, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234);
        chk("lhu_unsigned", last_wb, 32'h0000_8001);
        idle(1);
        // misaligned word, misaligned half, illegal size
        run_op(0, 2'b10, 0, 32'h0000_3001, 32'h0, 0, 0, 32'h0);
        run_op(1, 2'b01, 0, 32'h0000_3003, 32'h1234, 0, 0, 32'h0);
        run_op(0, 2'b11, 0, 32'h0000_3000, 32'h0, 0, 0, 32'h0);
        idle(1);
        // grant and rvalid stalls
        run_op(0, 2'b10, 0, 32'h0000_4000, 32'h0, 3, 2, 32'hCAFE_F00D);
        idle(2);
        // back-to-back: load presented in the store's done cycle
        run_op(1, 2'b10, 0, 32'h0000_5000, 32'h1122_3344, 1, 0, 32'h0);
        run_op(0, 2'b00, 0, 32'h0000_5001, 32'h0, 0, 1, 32'h0000_F700);
        idle(1);

        // reset while waiting for rvalid
        ex_valid = 1'b1; ex_we = 1'b0; ex_size = 2'b10; ex_addr = 32'h0000_6000;
        step();
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk("pre_rst_busy", lsu_busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_req", dmem_req, 0);
        chk("midrst_busy", lsu_busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        last_wb = 32'd0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 1'b0;
        chk("late_rv_wb_valid", wb_valid, 0);
        chk("late_rv_done", done, 0);
        chk("late_rv_wb_rdata", wb_rdata, 0);
        idle(1);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            logic        r_we_t;
            logic [1:0]  r_size_t;
            logic [31:0] r_addr_t;
            r_we_t   = 1'($urandom_range(0, 1));
            r_size_t = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_addr_t = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r_size_t == 2'b10) r_addr_t[1:0] = 2'b00;
                if (r_size_t == 2'b01) r_addr_t[0] = 1'b0;
            end
            run_op(r_we_t, r_size_t, 1'($urandom_range(0, 1)), r_addr_t, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
